// File: rtl/nibble_serial_subtractor.sv
// 16-bit subtractor a - b, one 4-bit lookahead-borrow nibble per clock, valid/ready on both sides.
// Optional zero/neg/ovf flag outputs are built when SUB_FLAGS_EN is defined.
module nibble_serial_subtractor (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_diff,
  output logic        o_bout
`ifdef SUB_FLAGS_EN
  ,
  output logic        o_zero,
  output logic        o_neg,
  output logic        o_ovf
`endif
);

  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned KW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic            r_borrow;
  logic            r_bout;
  logic [KW-1:0]   r_k;

  logic [3:0]      w_lsb;
  logic [NW-1:0]   w_an;
  logic [NW-1:0]   w_bn;
  logic [NW-1:0]   w_g;
  logic [NW-1:0]   w_p;
  logic [NW:0]     w_br;
  logic [NW-1:0]   w_res;
  logic            w_accept;
  logic            w_last;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_in_valid) w_next = S_CALC;
      S_CALC: if (w_last) w_next = S_DONE;
      S_DONE: if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  o_in_ready  = 1'b1;
      S_DONE:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_last   = (r_k == KW'(3));
  assign w_lsb    = {r_k, 2'b00};
  assign w_an     = r_a[w_lsb +: NW];
  assign w_bn     = r_b[w_lsb +: NW];
  assign w_g      = ~w_an & w_bn;
  assign w_p      = ~(w_an ^ w_bn);

  // Borrow chain flattened into lookahead terms, seeded by the inter-nibble borrow register
  assign w_br[0] = r_borrow;
  assign w_br[1] = w_g[0] | (w_p[0] & r_borrow);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
  assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
  assign w_res   = w_an ^ w_bn ^ w_br[NW-1:0];

  // Operand latch and serial datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_k      <= '0;
    end else if (w_accept) begin
      r_a      <= i_a;
      r_b      <= i_b;
      r_borrow <= 1'b0;
      r_k      <= '0;
    end else if (r_state == S_CALC) begin
      r_diff[w_lsb +: NW] <= w_res;
      r_borrow            <= w_br[NW];
      r_k                 <= r_k + KW'(1);
      if (w_last) begin
        r_bout <= w_br[NW];
      end
    end
  end

  assign o_diff = r_diff;
  assign o_bout = r_bout;

`ifdef SUB_FLAGS_EN
  logic         r_zero;
  logic         r_neg;
  logic         r_ovf;
  logic [W-1:0] w_full;

  // Final nibble is not yet in r_diff when flags are captured
  assign w_full = {w_res, r_diff[W-NW-1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == S_CALC) && w_last) begin
      r_zero <= (w_full == W'(0));
      r_neg  <= w_full[W-1];
      r_ovf  <= (r_a[W-1] != r_b[W-1]) && (w_full[W-1] != r_a[W-1]);
    end
  end

  assign o_zero = r_zero;
  assign o_neg  = r_neg;
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: directed steps, scoreboard of expected results.
// Flag checks are compiled in when SUB_FLAGS_EN is defined.
module tb_nibble_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int   total;
  int   bad;
  exp_t sb[$];

  nibble_serial_subtractor dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_diff      (diff),
    .o_bout      (bout)
`ifdef SUB_FLAGS_EN
    ,
    .o_zero      (zero),
    .o_neg       (neg),
    .o_ovf       (ovf)
`endif
  );

`ifndef SUB_FLAGS_EN
  assign zero = 1'b1;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb);
    exp_t e;
    e.diff = ma - mb;
    e.bout = (ma < mb);
    e.zero = (e.diff == 16'h0000);
    e.neg  = e.diff[15];
    e.ovf  = (ma[15] != mb[15]) && (e.diff[15] != ma[15]);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_result(input string tag, input exp_t e);
    chk({tag, "_diff"}, diff, e.diff);
    chk({tag, "_bout"}, 16'(bout), 16'(e.bout));
`ifdef SUB_FLAGS_EN
    chk({tag, "_zero"}, 16'(zero), 16'(e.zero));
    chk({tag, "_neg"},  16'(neg),  16'(e.neg));
    chk({tag, "_ovf"},  16'(ovf),  16'(e.ovf));
`endif
  endtask

  // Issue one operation, check latency, optionally stall output and pulse in_valid meanwhile
  task automatic run_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input int hold, input bit pulse);
    exp_t e;
    chk({tag, "_in_ready_idle"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    a        = oa;
    b        = ob;
    @(posedge clk);
    sb.push_back(model(oa, ob));
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~oa;
    b        = oa ^ ob;
    chk({tag, "_in_ready_calc"}, 16'(in_ready), 16'd0);
    chk({tag, "_ov_e0"}, 16'(out_valid), 16'd0);
    for (int n = 1; n <= 3; n++) begin
      cyc();
      chk({tag, "_ov_early"}, 16'(out_valid), 16'd0);
    end
    cyc();
    chk({tag, "_ov_e4"}, 16'(out_valid), 16'd1);
    for (int h = 0; h < hold; h++) begin
      in_valid = pulse && (h == 2);
      a        = 16'h1111;
      b        = 16'h2222;
      chk({tag, "_hold_in_ready"}, 16'(in_ready), 16'd0);
      chk({tag, "_hold_ov"}, 16'(out_valid), 16'd1);
      chk_result({tag, "_hold"}, sb[0]);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_ov_hs"}, 16'(out_valid), 16'd1);
    e = sb.pop_front();
    chk_result(tag, e);
    cyc();
    out_ready = 1'b0;
    chk({tag, "_in_ready_back"}, 16'(in_ready), 16'd1);
    chk({tag, "_ov_back"}, 16'(out_valid), 16'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    chk({tag, "_out_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_diff"}, diff, 16'h0000);
    chk({tag, "_bout"}, 16'(bout), 16'd0);
`ifdef SUB_FLAGS_EN
    chk({tag, "_zero"}, 16'(zero), 16'd1);
    chk({tag, "_neg"},  16'(neg),  16'd0);
    chk({tag, "_ovf"},  16'(ovf),  16'd0);
`endif
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    chk_reset_state("reset");

    run_op("t1234", 16'h1234, 16'h0234, 0, 1'b0);
    run_op("t0m1",  16'h0000, 16'h0001, 0, 1'b0);
    run_op("t8000", 16'h8000, 16'h0001, 0, 1'b0);
    run_op("t7fff", 16'h7FFF, 16'hFFFF, 0, 1'b0);
    run_op("tbp",   16'hABCD, 16'hABCD, 10, 1'b1);
    // The ignored pulse must not have started an operation
    cyc();
    chk("tbp_no_ghost_ov", 16'(out_valid), 16'd0);
    chk("tbp_no_ghost_ir", 16'(in_ready), 16'd1);

    // Reset during the second CALC cycle aborts the operation
    in_valid = 1'b1;
    a        = 16'hF0F0;
    b        = 16'h0F0F;
    @(posedge clk);
    sb.push_back(model(16'hF0F0, 16'h0F0F));
    @(negedge clk);
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    void'(sb.pop_back());
    chk_reset_state("midrst");
    run_op("t0005", 16'h0005, 16'h0003, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op("trand", ra, rb, i % 3, 1'b0);
    end

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
